// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: sample format, transform size,
// read-side state encoding and the bit-reversal helper.
package fft_pkg;

   localparam int DATA_W = 15;
   localparam int LOG2N  = 5;
   localparam int N      = 1 << LOG2N;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_e;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int b = 0; b < LOG2N; b++) begin
         r[b] = x[LOG2N-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two N-entry sample banks: one synchronous write port and one
// asynchronous read port, each with its own bank select.
module fft_pingpong_ram
   import fft_pkg::*;
(
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic                  wr_bank_i,
   input  logic [LOG2N-1:0]      wr_addr_i,
   input  logic [2*DATA_W-1:0]   wr_data_i,
   input  logic                  rd_bank_i,
   input  logic [LOG2N-1:0]      rd_addr_i,
   output logic [2*DATA_W-1:0]   rd_data_o
);

   logic [2*DATA_W-1:0] mem_q [2][N];

   // Bank contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_bank_i][rd_addr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT output frames into natural order using
// a ping-pong bank pair and a registered output stage.
module fft_bitrev_reorder
   import fft_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_r,
   output logic [DATA_W-1:0] out_i,
   output logic [LOG2N-1:0]  out_idx,
   output logic              out_last
);

   localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);

   rd_state_e          state_q, state_d;
   logic [1:0]         full_q, full_d;
   logic               wb_q, rb_q;
   logic [LOG2N-1:0]   wcnt_q, rcnt_q;
   logic               ov_q, olast_q;
   logic [DATA_W-1:0]  or_q, oi_q;
   logic [LOG2N-1:0]   oidx_q;

   logic               wr_en, wr_last;
   logic               avail, other_rdy;
   logic               load, rd_last;
   logic [2*DATA_W-1:0] rd_data;

   assign in_ready  = !full_q[wb_q] && !rst;
   assign wr_en     = in_valid && in_ready;
   assign wr_last   = wr_en && (wcnt_q == LAST);

   // A frame completing this cycle into the read bank counts as
   // available, so X[0] loads on the same edge as the last write.
   assign avail     = full_q[rb_q] || (wr_last && (wb_q == rb_q));
   assign other_rdy = full_q[~rb_q] || (wr_last && (wb_q != rb_q));
   assign load      = (!ov_q || out_ready)
                    && ((state_q == RD_STREAM) || avail);
   assign rd_last   = load && (rcnt_q == LAST);

   fft_pingpong_ram u_ram (
      .clk       (clk),
      .wr_en_i   (wr_en),
      .wr_bank_i (wb_q),
      .wr_addr_i (bitrev(wcnt_q)),
      .wr_data_i ({in_r, in_i}),
      .rd_bank_i (rb_q),
      .rd_addr_i (rcnt_q),
      .rd_data_o (rd_data)
   );

   // Read FSM next state and bank full-flag updates.
   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      if (state_q == RD_IDLE && avail) begin
         state_d = RD_STREAM;
      end
      if (wr_last) begin
         full_d[wb_q] = 1'b1;
      end
      if (rd_last) begin
         full_d[rb_q] = 1'b0;
         state_d      = other_rdy ? RD_STREAM : RD_IDLE;
      end
   end

   // Read FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bank pointers, sample counters and full flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= '0;
         wb_q   <= 1'b0;
         rb_q   <= 1'b0;
         wcnt_q <= '0;
         rcnt_q <= '0;
      end else begin
         full_q <= full_d;
         if (wr_en) begin
            wcnt_q <= wcnt_q + LOG2N'(1);
         end
         if (wr_last) begin
            wb_q <= ~wb_q;
         end
         if (load) begin
            rcnt_q <= rcnt_q + LOG2N'(1);
         end
         if (rd_last) begin
            rb_q <= ~rb_q;
         end
      end
   end

   // Output register: loads the next natural-order sample, holds
   // under backpressure, drains to empty when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ov_q    <= 1'b0;
         or_q    <= '0;
         oi_q    <= '0;
         oidx_q  <= '0;
         olast_q <= 1'b0;
      end else if (load) begin
         ov_q    <= 1'b1;
         or_q    <= rd_data[2*DATA_W-1:DATA_W];
         oi_q    <= rd_data[DATA_W-1:0];
         oidx_q  <= rcnt_q;
         olast_q <= (rcnt_q == LAST);
      end else if (state_q == RD_IDLE && out_ready) begin
         ov_q    <= 1'b0;
      end
   end

   assign out_valid = ov_q;
   assign out_r     = or_q;
   assign out_i     = oi_q;
   assign out_idx   = oidx_q;
   assign out_last  = olast_q;

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Output reorder buffer for the 32-point radix-2 SDF FFT pipeline. It consumes complex samples produced by the last butterfly stage in bit-reversed index order and emits them in natural order (X[0]..X[N-1]). It uses a ping-pong pair of N-entry banks, so one frame is written while the previous frame is read. This keeps the pipeline at one sample per clock with no stall under sustained traffic.

## Interface
- DATA_W, 15, width of each signed real/imag component (matches the butterfly output format: 7-bit integer, 8-bit fractional).
- LOG2N, 5, log2 of FFT length; N = 2^LOG2N.

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input sample present.
- in_ready  out  1  block can accept the input sample.
- in_r, in_i  in  DATA_W  signed sample; the k-th accepted sample of a frame is X[bitrev(k)].
- out_valid  out  1  output register holds a valid sample.
- out_ready  in  1  downstream accepts the output sample.
- out_r, out_i  out  DATA_W  signed sample X[out_idx].
- out_idx  out  LOG2N  natural-order index of the current output.
- out_last  out  1  high with out_idx == N-1.

## Operation
- Storage: two banks of N entries, each {re, im}, 2·DATA_W bits. Flags full[1:0]. Write-bank pointer wb, read-bank pointer rb. Counters wcnt and rcnt, each LOG2N bits.
- Write side:
  - in_ready = !full[wb] && !rst.
  - On in_valid && in_ready, write bank[wb][bitrev(wcnt)] and increment wcnt.
  - When wcnt == N-1 is accepted: set full[wb], toggle wb, wrap wcnt to 0.
- Read FSM with states IDLE and STREAM:
  - IDLE → STREAM when full[rb].
  - In STREAM, the output register loads when !out_valid || out_ready. It loads bank[rb][rcnt], with out_idx = rcnt, out_last = (rcnt == N-1), and rcnt increments.
  - On the load with rcnt == N-1: clear full[rb], toggle rb, wrap rcnt. Go to STREAM if the other bank is already full, else IDLE.
  - In IDLE, if out_ready is high, out_valid is cleared.
- A full flag may be set on one bank and cleared on the other in the same cycle; both updates take effect. The same bank is never set and cleared in one cycle, by construction.
- No arithmetic: data passes through bit-exact. bitrev reverses the LOG2N bits of the index.
- Both banks full: in_ready = 0, and input stalls until the reader frees a bank.
- Reset, including mid-frame:
  - Clears wb, rb, wcnt, rcnt and full, and sets the FSM to IDLE.
  - Outputs: out_valid = 0, out_r = out_i = 0, out_idx = 0, out_last = 0.
  - Any partial or unread frame is discarded. Bank contents are not cleared.

## Timing
- Read is asynchronous from the banks into the registered output stage, so there is one register stage on the output.
- Latency: if the final (N-th) input handshake of a frame occurs in cycle c, then in cycle c+1 out_valid = 1 with out_idx = 0, provided no earlier frame is pending.
- Throughput: with in_valid = 1 and out_ready = 1 continuously, in_ready never deasserts after reset and out_valid stays high continuously from the first output.
- Output hold: while out_valid && !out_ready, out_r, out_i, out_idx and out_last hold stable.
- in_ready is combinational from registered state only; it has no path from in_valid or out_ready.

## Structure
- Shared package fft_pkg: DATA_W = 15, LOG2N = 5, N, and the bitrev function. The same package is used by the butterfly stages and the twiddle ROM.
- Sub-module fft_pingpong_ram: two N × 2·DATA_W register-file banks with one write port (bank select, address, data, enable) and one asynchronous read port (bank select, address).
- The top level holds the pointers, counters, full flags, read FSM and output register.

## Test plan
- Single frame: accepted sample k carries re = bitrev(k), im = -bitrev(k) → outputs n = 0..31 have re = n and im = -n. out_last is high only at n = 31. out_valid first rises one cycle after the 32nd handshake.
- Streaming: 4 back-to-back frames with out_ready = 1 → in_ready stays 1, 128 contiguous out_valid cycles, every frame in natural order.
- Backpressure: out_ready = 0 while 3 frames are offered → 64 samples accepted, then in_ready = 0 and output held at idx 0 of frame 0. Release out_ready → all 96 samples emerge in order, with no loss and no duplication.
- Gapped traffic: random 50% in_valid and random 50% out_ready over 10 frames → a scoreboard matches the natural-order reference model.
- Reset mid-frame: rst high for one cycle after 10 samples of frame 1 while frame 0 is being output → out_valid = 0 on the next cycle and all outputs are zero. The next full frame is output correctly and the partial frame never appears.
- Extremes: re = -16384, im = 16383 (and the swapped values) at several indices → passed through bit-exact, with no sign or width corruption.
